// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// muldiv_ctrl : EX-stage mult/div sequencer and owner of the HI/LO registers
// Revision    : 1.0
// ---------------------------------------------------------------------------
module muldiv_ctrl #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        stallreq,
  output logic        busy,
  output logic        mul_signed,
  output logic [31:0] mul_ina,
  output logic [31:0] mul_inb,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_opdata1,
  output logic [31:0] div_opdata2,
  output logic        div_annul,
  input  logic [63:0] div_result,
  input  logic        div_ready,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam logic [3:0] c_mul_lat = 4'(MUL_LAT);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MUL_WAIT = 2'd1,
    S_DIV_RUN  = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [31:0] r_opa;
  logic [31:0] r_opb;
  logic        r_sgn;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_accept;
  logic        w_load_mul;
  logic        w_load_div;
  logic        w_hi_we;
  logic        w_lo_we;
  logic [31:0] w_hi_d;
  logic [31:0] w_lo_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // 110/111 are not muldiv operations and are never accepted
  assign w_accept = op_valid & ~flush & ~(op[2] & op[1]);

  always_comb begin
    w_state_nxt = r_state;
    w_load_mul  = 1'b0;
    w_load_div  = 1'b0;
    w_hi_we     = 1'b0;
    w_lo_we     = 1'b0;
    w_hi_d      = r_hi;
    w_lo_d      = r_lo;
    stallreq    = 1'b0;
    div_start   = 1'b0;
    div_annul   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (op)
            3'b000, 3'b001: begin
              w_load_mul  = 1'b1;
              stallreq    = 1'b1;
              w_state_nxt = S_MUL_WAIT;
            end
            3'b010, 3'b011: begin
              stallreq = 1'b1;
              if (src_b == 32'd0) begin
                w_hi_we     = 1'b1;
                w_hi_d      = src_a;
                w_lo_we     = 1'b1;
                w_lo_d      = 32'hFFFF_FFFF;
                w_state_nxt = S_DONE;
              end else begin
                w_load_div  = 1'b1;
                w_state_nxt = S_DIV_RUN;
              end
            end
            3'b100: begin
              w_hi_we = 1'b1;
              w_hi_d  = src_a;
            end
            3'b101: begin
              w_lo_we = 1'b1;
              w_lo_d  = src_a;
            end
            default: ;
          endcase
        end
      end
      S_MUL_WAIT: begin
        if (flush) begin
          w_state_nxt = S_IDLE;
        end else begin
          stallreq = 1'b1;
          if (r_cnt == 4'd1) begin
            w_hi_we     = 1'b1;
            w_hi_d      = mul_result[63:32];
            w_lo_we     = 1'b1;
            w_lo_d      = mul_result[31:0];
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DIV_RUN: begin
        if (flush) begin
          div_annul   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          stallreq  = 1'b1;
          div_start = 1'b1;
          if (div_ready) begin
            w_hi_we     = 1'b1;
            w_hi_d      = div_result[63:32];
            w_lo_we     = 1'b1;
            w_lo_d      = div_result[31:0];
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        // EX still presents the completed instruction here; do not re-accept it
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= 4'd0;
      r_opa <= 32'd0;
      r_opb <= 32'd0;
      r_sgn <= 1'b0;
      r_hi  <= 32'd0;
      r_lo  <= 32'd0;
    end else begin
      if (w_load_mul || w_load_div) begin
        r_opa <= src_a;
        r_opb <= src_b;
        r_sgn <= ~op[0];
      end
      if (w_load_mul)                  r_cnt <= c_mul_lat;
      else if (r_state == S_MUL_WAIT)  r_cnt <= r_cnt - 4'd1;
      if (w_hi_we) r_hi <= w_hi_d;
      if (w_lo_we) r_lo <= w_lo_d;
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign mul_signed  = (r_state == S_MUL_WAIT) & r_sgn;
  assign mul_ina     = (r_state == S_MUL_WAIT) ? r_opa : 32'd0;
  assign mul_inb     = (r_state == S_MUL_WAIT) ? r_opb : 32'd0;
  assign div_signed  = (r_state == S_DIV_RUN) & r_sgn;
  assign div_opdata1 = (r_state == S_DIV_RUN) ? r_opa : 32'd0;
  assign div_opdata2 = (r_state == S_DIV_RUN) ? r_opb : 32'd0;
  assign hi_o        = r_hi;
  assign lo_o        = r_lo;

endmodule
`default_nettype wire
